// File: rtl/load_store_seq_ctrl.sv
// Load/store sequencer: steps memory read, MDR capture, write and writeback for LW/LH/LB/SW/SH/SB/WTEMP.
// Optional MISALIGN_TRAP_EN adds the misalign output and traps misaligned word/half accesses to FIN.
module load_store_seq_ctrl #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [1:0] addr_lo,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       mdr_load,
    output logic [1:0] size_sel,
    output logic [1:0] byte_off,
    output logic       data_src_sel,
    output logic       reg_wr,
    output logic       busy,
    output logic       done
`ifdef MISALIGN_TRAP_EN
    ,
    output logic       misalign
`endif
);

    localparam logic [2:0] OP_LW    = 3'b000;
    localparam logic [2:0] OP_LH    = 3'b001;
    localparam logic [2:0] OP_LB    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_SH    = 3'b100;
    localparam logic [2:0] OP_SB    = 3'b101;
    localparam logic [2:0] OP_WTEMP = 3'b110;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_WB,
        S_FIN
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q, nxt_op;
    logic [1:0]         size_q, off_q, nxt_size;
    logic [1:0]         nxt_off;
    logic               accept;
    state_t             acc_state;
    logic [1:0]         acc_size, acc_off;
    logic               nxt_mem_rd, nxt_mem_wr, nxt_mdr_load, nxt_reg_wr;
    logic               nxt_sel, nxt_done, nxt_busy;
    logic [1:0]         nxt_size_o, nxt_off_o;
`ifdef MISALIGN_TRAP_EN
    logic               acc_mis, mis_q, nxt_mis, nxt_misalign;
`endif

    // Decode of the incoming op: first state, size mode and lane offset.
    always_comb begin
        acc_state = S_FIN;
        acc_size  = SZ_WORD;
        acc_off   = 2'b00;
`ifdef MISALIGN_TRAP_EN
        acc_mis   = 1'b0;
`endif
        case (op)
            OP_LW, OP_SW: begin
                acc_state = (op == OP_LW) ? S_READ : S_WRITE;
                acc_size  = SZ_WORD;
                acc_off   = 2'b00;
`ifdef MISALIGN_TRAP_EN
                acc_mis   = (addr_lo != 2'b00);
`endif
            end
            OP_LH, OP_SH: begin
                acc_state = S_READ;
                acc_size  = SZ_HALF;
                acc_off   = {addr_lo[1], 1'b0};
`ifdef MISALIGN_TRAP_EN
                acc_mis   = addr_lo[0];
`endif
            end
            OP_LB, OP_SB: begin
                acc_state = S_READ;
                acc_size  = SZ_BYTE;
                acc_off   = addr_lo;
            end
            OP_WTEMP: acc_state = S_WB;
            default:  acc_state = S_FIN;
        endcase
`ifdef MISALIGN_TRAP_EN
        if (acc_mis) begin
            acc_state = S_FIN;
        end
`endif
    end

    // Next state; terminal states may take a new op directly so back-to-back ops have no bubble.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE:    accept = start;
            S_READ:    if (cnt == '0) next_state = S_CAPTURE;
            S_CAPTURE: next_state = (op_q == OP_LW || op_q == OP_LH || op_q == OP_LB) ? S_WB : S_WRITE;
            S_WRITE, S_WB, S_FIN: begin
                accept     = start;
                next_state = S_IDLE;
            end
            default:   next_state = S_IDLE;
        endcase
        if (accept) begin
            next_state = acc_state;
        end
        nxt_op   = accept ? op : op_q;
        nxt_size = accept ? acc_size : size_q;
        nxt_off  = accept ? acc_off : off_q;
`ifdef MISALIGN_TRAP_EN
        nxt_mis  = accept ? acc_mis : mis_q;
`endif
    end

    // Outputs are decoded from the next state and registered, so they are Moore and glitch-free.
    always_comb begin
        nxt_mem_rd   = 1'b0;
        nxt_mem_wr   = 1'b0;
        nxt_mdr_load = 1'b0;
        nxt_reg_wr   = 1'b0;
        nxt_sel      = 1'b0;
        nxt_done     = 1'b0;
        nxt_busy     = (next_state != S_IDLE);
        nxt_size_o   = (next_state == S_IDLE) ? 2'b00 : nxt_size;
        nxt_off_o    = (next_state == S_IDLE) ? 2'b00 : nxt_off;
`ifdef MISALIGN_TRAP_EN
        nxt_misalign = 1'b0;
`endif
        case (next_state)
            S_READ:    nxt_mem_rd = 1'b1;
            S_CAPTURE: nxt_mdr_load = 1'b1;
            S_WRITE: begin
                nxt_mem_wr = 1'b1;
                nxt_done   = 1'b1;
            end
            S_WB: begin
                nxt_reg_wr = 1'b1;
                nxt_done   = 1'b1;
                nxt_sel    = (nxt_op != OP_WTEMP);
            end
            S_FIN: begin
                nxt_done     = 1'b1;
`ifdef MISALIGN_TRAP_EN
                nxt_misalign = nxt_mis;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op_q         <= 3'b000;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mdr_load     <= 1'b0;
            reg_wr       <= 1'b0;
            data_src_sel <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            size_sel     <= 2'b00;
            byte_off     <= 2'b00;
`ifdef MISALIGN_TRAP_EN
            mis_q        <= 1'b0;
            misalign     <= 1'b0;
`endif
        end else begin
            state        <= next_state;
            op_q         <= nxt_op;
            size_q       <= nxt_size;
            off_q        <= nxt_off;
            if (next_state == S_READ && state != S_READ) begin
                cnt <= CNT_W'(MEM_LATENCY - 1);
            end else if (state == S_READ && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            mem_rd       <= nxt_mem_rd;
            mem_wr       <= nxt_mem_wr;
            mdr_load     <= nxt_mdr_load;
            reg_wr       <= nxt_reg_wr;
            data_src_sel <= nxt_sel;
            done         <= nxt_done;
            busy         <= nxt_busy;
            size_sel     <= nxt_size_o;
            byte_off     <= nxt_off_o;
`ifdef MISALIGN_TRAP_EN
            mis_q        <= nxt_mis;
            misalign     <= nxt_misalign;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_seq_ctrl.sv
// Directed bench for load_store_seq_ctrl: one instance with MEM_LATENCY=1, one with MEM_LATENCY=3.
// Packed observation: {misalign, mem_rd, mem_wr, mdr_load, reg_wr, data_src_sel, done, busy, size_sel, byte_off}.
module tb_load_store_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start1, start3;
    logic [2:0] op;
    logic [1:0] addr_lo;

    logic       mem_rd1, mem_wr1, mdr_load1, sel1, reg_wr1, busy1, done1, mis1;
    logic [1:0] size1, off1;
    logic       mem_rd3, mem_wr3, mdr_load3, sel3, reg_wr3, busy3, done3, mis3;
    logic [1:0] size3, off3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_seq_ctrl #(.MEM_LATENCY(1), .CNT_W(3)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .op(op), .addr_lo(addr_lo),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mdr_load(mdr_load1), .size_sel(size1),
        .byte_off(off1), .data_src_sel(sel1), .reg_wr(reg_wr1), .busy(busy1), .done(done1)
`ifdef MISALIGN_TRAP_EN
        , .misalign(mis1)
`endif
    );

    load_store_seq_ctrl #(.MEM_LATENCY(3), .CNT_W(3)) u3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .op(op), .addr_lo(addr_lo),
        .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mdr_load(mdr_load3), .size_sel(size3),
        .byte_off(off3), .data_src_sel(sel3), .reg_wr(reg_wr3), .busy(busy3), .done(done3)
`ifdef MISALIGN_TRAP_EN
        , .misalign(mis3)
`endif
    );

`ifndef MISALIGN_TRAP_EN
    assign mis1 = 1'b0;
    assign mis3 = 1'b0;
`endif

    logic [11:0] o1, o3;
    assign o1 = {mis1, mem_rd1, mem_wr1, mdr_load1, reg_wr1, sel1, done1, busy1, size1, off1};
    assign o3 = {mis3, mem_rd3, mem_wr3, mdr_load3, reg_wr3, sel3, done3, busy3, size3, off3};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start1  = 1'b0;
        start3  = 1'b0;
        op      = 3'b000;
        addr_lo = 2'b00;
        #12;
        chk("reset_u1", o1, 12'b0);
        chk("reset_u3", o3, 12'b0);
        tick;
        reset_n = 1'b1;
        tick;

        // LB addr 11, latency 1
        op = 3'b010; addr_lo = 2'b11; start1 = 1'b1;
        tick; start1 = 1'b0;
        chk("lb_read",  o1, {8'b0100_0001, 4'b1011});
        tick; chk("lb_capt", o1, {8'b0001_0001, 4'b1011});
        tick; chk("lb_wb",   o1, {8'b0000_1111, 4'b1011});
        tick; chk("lb_idle", o1, 12'b0);

        // SH addr 10, latency 3: read-modify-write
        op = 3'b100; addr_lo = 2'b10; start3 = 1'b1;
        tick; start3 = 1'b0;
        chk("sh_read1", o3, {8'b0100_0001, 4'b0110});
        tick; chk("sh_read2", o3, {8'b0100_0001, 4'b0110});
        tick; chk("sh_read3", o3, {8'b0100_0001, 4'b0110});
        tick; chk("sh_capt",  o3, {8'b0001_0001, 4'b0110});
        tick; chk("sh_write", o3, {8'b0010_0011, 4'b0110});
        tick; chk("sh_idle",  o3, 12'b0);

        // WTEMP then LW back-to-back
        op = 3'b110; addr_lo = 2'b00; start1 = 1'b1;
        tick;
        chk("wtemp_wb", o1, {8'b0000_1011, 4'b0000});
        op = 3'b000; addr_lo = 2'b00;
        tick; start1 = 1'b0;
        chk("b2b_read", o1, {8'b0100_0001, 4'b0000});
        tick; chk("b2b_capt", o1, {8'b0001_0001, 4'b0000});
        tick; chk("b2b_wb",   o1, {8'b0000_1111, 4'b0000});
        tick; chk("b2b_idle", o1, 12'b0);

        // SW: single write cycle
        op = 3'b011; addr_lo = 2'b00; start1 = 1'b1;
        tick; start1 = 1'b0;
        chk("sw_write", o1, {8'b0010_0011, 4'b0000});
        tick; chk("sw_idle", o1, 12'b0);

        // Reset asserted during READ of an LW
        op = 3'b000; addr_lo = 2'b00; start3 = 1'b1;
        tick; start3 = 1'b0;
        chk("rst_pre", o3, {8'b0100_0001, 4'b0000});
        tick;
        reset_n = 1'b0;
        #1;
        chk("rst_async", o3, 12'b0);
        tick; chk("rst_hold", o3, 12'b0);
        reset_n = 1'b1;
        tick; chk("rst_after", o3, 12'b0);
        tick; chk("rst_after2", o3, 12'b0);
        start3 = 1'b1;
        tick; start3 = 1'b0;
        chk("lw3_read1", o3, {8'b0100_0001, 4'b0000});
        tick; chk("lw3_read2", o3, {8'b0100_0001, 4'b0000});
        tick; chk("lw3_read3", o3, {8'b0100_0001, 4'b0000});
        tick; chk("lw3_capt",  o3, {8'b0001_0001, 4'b0000});
        tick; chk("lw3_wb",    o3, {8'b0000_1111, 4'b0000});
        tick; chk("lw3_idle",  o3, 12'b0);

        // Misaligned LW addr 01
        op = 3'b000; addr_lo = 2'b01; start1 = 1'b1;
        tick; start1 = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("mis_fin",  o1, {8'b1000_0011, 4'b0000});
        tick; chk("mis_idle", o1, 12'b0);
`else
        chk("mis_read", o1, {8'b0100_0001, 4'b0000});
        tick; chk("mis_capt", o1, {8'b0001_0001, 4'b0000});
        tick; chk("mis_wb",   o1, {8'b0000_1111, 4'b0000});
        tick; chk("mis_idle", o1, 12'b0);
`endif

        // SB with start re-pulsed while busy; op/addr changed to prove the latch holds
        op = 3'b101; addr_lo = 2'b01; start3 = 1'b1;
        tick;
        op = 3'b000; addr_lo = 2'b00;
        chk("sb_read1", o3, {8'b0100_0001, 4'b1001});
        tick; chk("sb_read2", o3, {8'b0100_0001, 4'b1001});
        tick; chk("sb_read3", o3, {8'b0100_0001, 4'b1001});
        tick; chk("sb_capt",  o3, {8'b0001_0001, 4'b1001});
        tick; start3 = 1'b0;
        chk("sb_write", o3, {8'b0010_0011, 4'b1001});
        tick; chk("sb_idle", o3, 12'b0);
        tick; chk("sb_idle2", o3, 12'b0);

        // Reserved op: done only
        op = 3'b111; addr_lo = 2'b10; start1 = 1'b1;
        tick; start1 = 1'b0;
        chk("rsvd_fin",  o1, {8'b0000_0011, 4'b0000});
        tick; chk("rsvd_idle", o1, 12'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
